// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Shares one BIT_WIDTH-bit ripple adder between two requesters.
//   Round-robin arbitration. Each add takes two cycles: grant/capture, then add.
//   The tagged result is held until the consumer accepts it.
// Ports
//   clk, n_rst               clock (rising edge), async active-low reset
//   req[1:0]                 per-requester operand-valid, held until grant
//   a0/b0/cin0, a1/b1/cin1   operands of requester 0 / 1
//   grant[1:0]               one-hot, combinational, one-cycle capture pulse
//   result_ready             consumer accept
//   result_valid, result_id  result handshake and owner tag
//   sum, overflow            registered adder outputs

// One bit of the ripple chain.
module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// Ripple-carry adder built from an array of full adder cells.
module adder_nbit #(
  parameter int BIT_WIDTH = 16
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 overflow
);
  logic [BIT_WIDTH:0] w_c;

  assign w_c[0]   = carry_in;
  assign overflow = w_c[BIT_WIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < BIT_WIDTH; gi++) begin : g_bit
      full_adder_cell u_fa (
        .i_a (a[gi]),
        .i_b (b[gi]),
        .i_c (w_c[gi]),
        .o_s (sum[gi]),
        .o_c (w_c[gi+1])
      );
    end
  endgenerate
endmodule

module adder_share_arbiter #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [1:0]           req,
  input  logic [BIT_WIDTH-1:0] a0,
  input  logic [BIT_WIDTH-1:0] b0,
  input  logic                 cin0,
  input  logic [BIT_WIDTH-1:0] a1,
  input  logic [BIT_WIDTH-1:0] b1,
  input  logic                 cin1,
  output logic [1:0]           grant,
  input  logic                 result_ready,
  output logic                 result_valid,
  output logic                 result_id,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state, w_next;
  logic [BIT_WIDTH-1:0] r_a, r_b, r_sum;
  logic                 r_cin, r_ovf, r_id;
  // Index of the most recent winner; reset to 1 so requester 0 wins the
  // first contention.
  logic                 r_last_grant;

  logic                 w_accept, w_win, w_take;
  logic [BIT_WIDTH-1:0] w_sum;
  logic                 w_cout;

  // The adder only ever sees the captured operands, so late changes on the
  // requester buses cannot disturb an add in flight.
  adder_nbit #(.BIT_WIDTH(BIT_WIDTH)) u_add (
    .a        (r_a),
    .b        (r_b),
    .carry_in (r_cin),
    .sum      (w_sum),
    .overflow (w_cout)
  );

  // Arbitration and next state.
  always_comb begin
    w_accept = (r_state == S_IDLE) || ((r_state == S_DONE) && result_ready);
    w_win    = 1'b0;
    case (req)
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last_grant;
      default: w_win = 1'b0;
    endcase
    w_take = w_accept && (req != 2'b00);
    grant  = 2'b00;
    if (w_take) grant = w_win ? 2'b10 : 2'b01;

    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_take) w_next = S_ADD;
      S_ADD:   w_next = S_DONE;
      S_DONE:  if (result_ready) w_next = w_take ? S_ADD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Operand capture at the grant edge; result capture at the end of ADD.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_cin        <= 1'b0;
      r_last_grant <= 1'b1;
      r_sum        <= '0;
      r_ovf        <= 1'b0;
      r_id         <= 1'b0;
    end else begin
      if (w_take) begin
        r_a          <= w_win ? a1 : a0;
        r_b          <= w_win ? b1 : b0;
        r_cin        <= w_win ? cin1 : cin0;
        r_last_grant <= w_win;
      end
      if (r_state == S_ADD) begin
        r_sum <= w_sum;
        r_ovf <= w_cout;
        // last_grant still holds the winner of the add in flight.
        r_id  <= r_last_grant;
      end
    end
  end

  assign result_valid = (r_state == S_DONE);
  assign result_id    = r_id;
  assign sum          = r_sum;
  assign overflow     = r_ovf;

  // Unknown request or carry-in while the arbiter is listening is a
  // protocol error on the requester side.
  always @(posedge clk) begin
    if (n_rst && w_accept) begin
      assert (!$isunknown(req)) else $error("req unknown while accepting");
      if (grant[0]) assert (!$isunknown(cin0)) else $error("cin0 unknown at grant");
      if (grant[1]) assert (!$isunknown(cin1)) else $error("cin1 unknown at grant");
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic         cin0, cin1;
  logic [1:0]   grant;
  logic         result_ready, result_valid, result_id, overflow;
  logic [W-1:0] sum;

  int n_chk = 0;
  int n_err = 0;

  adder_share_arbiter #(.BIT_WIDTH(W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .req          (req),
    .a0           (a0),
    .b0           (b0),
    .cin0         (cin0),
    .a1           (a1),
    .b1           (b1),
    .cin1         (cin1),
    .grant        (grant),
    .result_ready (result_ready),
    .result_valid (result_valid),
    .result_id    (result_id),
    .sum          (sum),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks happen on the
  // falling edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #3;
    n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // One isolated transaction from IDLE with result_ready held high.
  task automatic one_op(input string tag, input logic r, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic eo);
    if (r) begin a1 = a; b1 = b; cin1 = c; req = 2'b10; end
    else   begin a0 = a; b0 = b; cin0 = c; req = 2'b01; end
    @(negedge clk);
    chk({tag, ".grant"}, 32'(grant), r ? 32'h2 : 32'h1);
    tick(); req = 2'b00;
    @(negedge clk);
    chk({tag, ".vld_add"}, 32'(result_valid), 32'h0);
    tick();
    @(negedge clk);
    chk({tag, ".vld"}, 32'(result_valid), 32'h1);
    chk({tag, ".sum"}, 32'(sum), 32'(es));
    chk({tag, ".ovf"}, 32'(overflow), 32'(eo));
    chk({tag, ".id"},  32'(result_id), 32'(r));
    tick();
  endtask

  initial begin
    n_rst = 1'b1; req = 2'b00; result_ready = 1'b1;
    a0 = '0; b0 = '0; cin0 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    chk("rst.vld", 32'(result_valid), 32'h0);
    chk("rst.sum", 32'(sum), 32'h0);
    chk("rst.ovf", 32'(overflow), 32'h0);
    chk("rst.id",  32'(result_id), 32'h0);
    chk("rst.grant", 32'(grant), 32'h0);
    n_rst = 1'b1;
    tick();

    // Basic adds.
    one_op("op0", 1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
    one_op("op1", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    one_op("op2", 1'b1, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0);

    // Round-robin under continuous contention, starting from reset.
    do_reset();
    a0 = 16'h0001; b0 = 16'h0001; cin0 = 1'b0;
    a1 = 16'h0002; b1 = 16'h0003; cin1 = 1'b0;
    req = 2'b11; result_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d.grant", k), 32'(grant), (k % 2) ? 32'h2 : 32'h1);
      if (k > 0) begin
        chk($sformatf("rr%0d.vld", k), 32'(result_valid), 32'h1);
        chk($sformatf("rr%0d.id", k), 32'(result_id), 32'((k + 1) % 2));
        chk($sformatf("rr%0d.sum", k), 32'(sum), (k % 2) ? 32'h2 : 32'h5);
      end
      tick();
      @(negedge clk);
      chk($sformatf("rr%0d.add_grant", k), 32'(grant), 32'h0);
      chk($sformatf("rr%0d.add_vld", k), 32'(result_valid), 32'h0);
      if (k == 3) result_ready = 1'b0;
      tick();
    end

    // Backpressure: DONE with requester 1's result (2+3), both still asking.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d.grant", k), 32'(grant), 32'h0);
      chk($sformatf("bp%0d.vld", k), 32'(result_valid), 32'h1);
      chk($sformatf("bp%0d.id", k), 32'(result_id), 32'h1);
      chk($sformatf("bp%0d.sum", k), 32'(sum), 32'h5);
      chk($sformatf("bp%0d.ovf", k), 32'(overflow), 32'h0);
      tick();
    end
    result_ready = 1'b1;
    #1;
    chk("bp.release_grant", 32'(grant), 32'h1);
    tick(); req = 2'b00;
    tick();
    @(negedge clk);
    chk("bp.after_id", 32'(result_id), 32'h0);
    chk("bp.after_sum", 32'(sum), 32'h2);
    tick();

    // Operand change after the grant edge must not affect the add.
    a0 = 16'h0001; b0 = 16'h0001; cin0 = 1'b0; req = 2'b01;
    @(negedge clk);
    chk("late.grant", 32'(grant), 32'h1);
    tick(); req = 2'b00; a0 = 16'hAAAA;
    tick();
    @(negedge clk);
    chk("late.vld", 32'(result_valid), 32'h1);
    chk("late.sum", 32'(sum), 32'h0002);
    tick();

    // Reset during ADD; requester 0 is last winner, so the fairness pointer
    // must be restored for requester 0 to win the next contention.
    a0 = 16'h4000; b0 = 16'h4000; req = 2'b01;
    tick(); req = 2'b00;
    #2 n_rst = 1'b0;
    #1;
    chk("mrst.vld", 32'(result_valid), 32'h0);
    chk("mrst.sum", 32'(sum), 32'h0);
    n_rst = 1'b1;
    req = 2'b11;
    @(negedge clk);
    chk("mrst.grant", 32'(grant), 32'h1);
    tick(); req = 2'b00;
    tick();
    @(negedge clk);
    chk("mrst.res_sum", 32'(sum), 32'h8000);
    chk("mrst.res_id", 32'(result_id), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one instance of the 16-bit ripple adder between two requesters using round-robin arbitration.
- Each requester presents operands under a req/grant handshake. The arbiter captures the winner's operands, sequences the add, and holds the tagged result until the consumer accepts it.
- Sits between the two operand sources and the shared adder; it is the only block that drives the adder inputs.

Parameters:
- BIT_WIDTH, 16, operand/sum width; passed to the adder instance (adder_nbit, BIT_WIDTH).

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  asynchronous active-low reset.
- req  input  2  req[i] high = requester i has valid operands; held until grant[i].
- a0  input  BIT_WIDTH  requester 0 operand a.
- b0  input  BIT_WIDTH  requester 0 operand b.
- cin0  input  1  requester 0 carry_in.
- a1  input  BIT_WIDTH  requester 1 operand a.
- b1  input  BIT_WIDTH  requester 1 operand b.
- cin1  input  1  requester 1 carry_in.
- grant  output  2  one-hot, one-cycle pulse; operands of that requester are captured at this clock edge.
- result_ready  input  1  consumer accepts the result when high together with result_valid.
- result_valid  output  1  sum/overflow/result_id are valid.
- result_id  output  1  index of the requester the result belongs to.
- sum  output  BIT_WIDTH  registered adder sum.
- overflow  output  1  registered carry-out of the MSB from the adder.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (n_rst).
- Reset values: state=IDLE, operand regs=0, sum=0, overflow=0, result_valid=0, result_id=0, last_grant=1. last_grant=1 means requester 0 wins first contention.
- FSM states: IDLE, ADD, DONE.
- Accept condition: (state==IDLE) or (state==DONE and result_ready).
- grant is combinational: when the accept condition holds and req!=0, grant the winner for that cycle. On that edge, capture the winner's a/b/cin into operand regs, set last_grant=winner, and go to ADD.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester != last_grant wins.
  - grant is never asserted outside the accept condition and never has two bits set.
- ADD (exactly 1 cycle): the adder sees the operand regs. At the clock edge, register sum, overflow, and result_id=winner; go to DONE.
- DONE: result_valid=1. Outputs stay stable until result_ready=1.
  - result_ready=1 and no req: go to IDLE; result_valid drops to 0 next cycle.
  - result_ready=1 and req pending: back-to-back grant in the same cycle; go to ADD; result_valid drops next cycle.
  - result_ready=0: stay in DONE, no grants. This is backpressure: requesters wait with req held.
- Latency: grant in cycle t, result_valid first high in cycle t+2. Peak throughput is one result per 2 cycles.
- Arithmetic: sum = (a+b+cin) mod 2^BIT_WIDTH; overflow = carry out of bit BIT_WIDTH-1. Example: FFFF+0001+0 gives sum 0000, overflow 1.
- Operands sampled only at the grant edge; later changes on a*/b*/cin* do not affect an in-flight add.
- A requester deasserting req before grant is legal; its request is simply dropped.
- Reset mid-operation (any state): in-flight operation discarded, all registers return to reset values immediately (async).
- Assertion: $error if req, or the granted requester's cin, is non-0/1 when the accept condition holds.

Test Plan:
- Reset, then req=01 with a0=0x1234, b0=0x1111, cin0=0 -> grant=01 same cycle; 2 cycles later result_valid=1, sum=0x2345, overflow=0, result_id=0.
- req=10 with a1=0xFFFF, b1=0x0001, cin1=0 -> sum=0x0000, overflow=1, result_id=1. Repeat with a1=0x7FFF, b1=0x0000, cin1=1 -> sum=0x8000, overflow=0.
- Both req held continuously, result_ready=1 -> grants alternate 01,10,01,10 (first 01 after reset); result_valid pulses every 2 cycles with alternating result_id.
- result_ready=0 for 5 cycles while DONE, both req high -> sum/overflow/result_id stable, grant=00 throughout. Raising result_ready -> grant issued the same cycle.
- Change a0 to 0xAAAA the cycle after grant (original a0=0x0001, b0=0x0001) -> sum=0x0002, unaffected.
- Assert n_rst=0 during ADD -> result_valid=0, sum=0, state IDLE at once. After release, both req high -> requester 0 granted first.
